getreg: RTL and testbench
=========================

Name: getreg

Overview:
- Translates RISC-V 5-bit register indices into ASCII ABI register-name strings for the instruction disassembler/decoder.
- Three independent lookup lanes (rd, rs1, rs2) run in parallel, so one decoded instruction's operands are named in a single transaction.
- Output strings are packed right-justified, so downstream equality checks against string literals (e.g. "zero") are exact.

Parameters:
- REG_OUT, 1, 1 = results registered (1-cycle latency); 0 = combinational outputs (0 latency; clk/rst_n affect out_valid only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  lookup request strobe; indices sampled when high.
- idx_rd  in  5  destination register index.
- idx_rs1  in  5  source-1 register index.
- idx_rs2  in  5  source-2 register index.
- out_valid  out  1  names valid for the request issued the previous cycle.
- name_rd  out  32  ASCII name of idx_rd.
- name_rs1  out  32  ASCII name of idx_rs1.
- name_rs2  out  32  ASCII name of idx_rs2.

Behaviour:
- Encoding:
  - 4 bytes, most significant byte is the first character.
  - Names shorter than 4 characters are right-justified with leading 8'h00 bytes.
  - Example: "ra" = 32'h0000_7261; "zero" = 32'h7A65_726F.
- Integer mapping:
  - x0 zero, x1 ra, x2 sp, x3 gp, x4 tp.
  - x5-x7 t0-t2.
  - x8 s0 (never "fp"), x9 s1.
  - x10-x17 a0-a7.
  - x18-x27 s2-s11.
  - x28-x31 t3-t6.
- Lanes:
  - Each lane uses the same pure lookup function; there is no cross-lane interaction.
  - Identical indices on several lanes give identical names.
- Timing with REG_OUT=1:
  - On a rising clk edge with in_valid=1, all three name registers load the lookup results and out_valid<=1.
  - With in_valid=0, the names hold their previous values and out_valid<=0.
  - Back-to-back requests are supported; throughput is 1 request/cycle and there is no backpressure.
- Timing with REG_OUT=0:
  - Names are combinational from the indices.
  - out_valid = in_valid.
- Reset:
  - rst_n low immediately clears out_valid to 0 and all names to 32'h0, independent of clk.
  - A request presented during reset is dropped.
  - The first capture happens on the first rising edge after rst_n deasserts.
- Every 5-bit index value is legal. There is no error output and no X may ever propagate to the outputs.

Optional Feature:
- Macro GETREG_FP_NAMES_EN.
- When defined:
  - Add input port fp_sel (3 bits, bit0=rd, bit1=rs1, bit2=rs2), sampled with in_valid.
  - A lane whose bit is 1 uses floating-point ABI names: f0-f7 ft0-ft7, f8-f9 fs0-fs1, f10-f17 fa0-fa7, f18-f27 fs2-fs11, f28-f31 ft8-ft11.
  - Example: fs11 = 32'h6673_3131.
- When undefined:
  - The fp_sel port does not exist.
  - All lanes always use the integer mapping.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid=0 and all names 32'h0 at once. Deassert, idle -> outputs stay 0.
- Sweep: REG_OUT=1, indices 0..31 applied to all lanes on consecutive cycles -> one cycle later each name matches the table:
  - idx 0 -> 32'h7A65726F.
  - idx 1 -> 32'h00007261.
  - idx 8 -> 32'h00007330.
  - idx 26 -> 32'h00733130.
  - idx 31 -> 32'h00007436.
- Mixed lanes: rd=10, rs1=2, rs2=0 with in_valid=1 -> name_rd=32'h00006130, name_rs1=32'h00007370, name_rs2=32'h7A65726F, out_valid=1 next cycle.
- Hold: a request, then in_valid=0 for 3 cycles with indices changing -> names unchanged, out_valid=0.
- Comb mode: REG_OUT=0, idx_rd toggles 5->28 -> name_rd goes 32'h00007430->32'h00007433 in the same cycle; out_valid tracks in_valid.
- FP (GETREG_FP_NAMES_EN): fp_sel=3'b001, rd=rs1=27 -> name_rd=32'h66733131, name_rs1=32'h00733131.

Source files
------------

// File: rtl/getreg.sv
// getreg: maps RISC-V 5-bit register indices to right-justified ASCII ABI names on three parallel lanes.
// Optional macro GETREG_FP_NAMES_EN adds fp_sel so each lane can use floating-point ABI names instead.
module getreg #(
  parameter int REG_OUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  idx_rd,
  input  logic [4:0]  idx_rs1,
  input  logic [4:0]  idx_rs2,
`ifdef GETREG_FP_NAMES_EN
  input  logic [2:0]  fp_sel,
`endif
  output logic        out_valid,
  output logic [31:0] name_rd,
  output logic [31:0] name_rs1,
  output logic [31:0] name_rs2
);

  // Integer ABI names; x8 is always "s0", never "fp".
  function automatic logic [31:0] int_name(input logic [4:0] idx);
    logic [31:0] n;
    case (idx)
      5'd0:    n = "zero";
      5'd1:    n = {16'h0, "ra"};
      5'd2:    n = {16'h0, "sp"};
      5'd3:    n = {16'h0, "gp"};
      5'd4:    n = {16'h0, "tp"};
      5'd5:    n = {16'h0, "t0"};
      5'd6:    n = {16'h0, "t1"};
      5'd7:    n = {16'h0, "t2"};
      5'd8:    n = {16'h0, "s0"};
      5'd9:    n = {16'h0, "s1"};
      5'd10:   n = {16'h0, "a0"};
      5'd11:   n = {16'h0, "a1"};
      5'd12:   n = {16'h0, "a2"};
      5'd13:   n = {16'h0, "a3"};
      5'd14:   n = {16'h0, "a4"};
      5'd15:   n = {16'h0, "a5"};
      5'd16:   n = {16'h0, "a6"};
      5'd17:   n = {16'h0, "a7"};
      5'd18:   n = {16'h0, "s2"};
      5'd19:   n = {16'h0, "s3"};
      5'd20:   n = {16'h0, "s4"};
      5'd21:   n = {16'h0, "s5"};
      5'd22:   n = {16'h0, "s6"};
      5'd23:   n = {16'h0, "s7"};
      5'd24:   n = {16'h0, "s8"};
      5'd25:   n = {16'h0, "s9"};
      5'd26:   n = {8'h0, "s10"};
      5'd27:   n = {8'h0, "s11"};
      5'd28:   n = {16'h0, "t3"};
      5'd29:   n = {16'h0, "t4"};
      5'd30:   n = {16'h0, "t5"};
      default: n = {16'h0, "t6"};
    endcase
    return n;
  endfunction

`ifdef GETREG_FP_NAMES_EN
  function automatic logic [31:0] fp_name(input logic [4:0] idx);
    logic [31:0] n;
    case (idx)
      5'd0:    n = {8'h0, "ft0"};
      5'd1:    n = {8'h0, "ft1"};
      5'd2:    n = {8'h0, "ft2"};
      5'd3:    n = {8'h0, "ft3"};
      5'd4:    n = {8'h0, "ft4"};
      5'd5:    n = {8'h0, "ft5"};
      5'd6:    n = {8'h0, "ft6"};
      5'd7:    n = {8'h0, "ft7"};
      5'd8:    n = {8'h0, "fs0"};
      5'd9:    n = {8'h0, "fs1"};
      5'd10:   n = {8'h0, "fa0"};
      5'd11:   n = {8'h0, "fa1"};
      5'd12:   n = {8'h0, "fa2"};
      5'd13:   n = {8'h0, "fa3"};
      5'd14:   n = {8'h0, "fa4"};
      5'd15:   n = {8'h0, "fa5"};
      5'd16:   n = {8'h0, "fa6"};
      5'd17:   n = {8'h0, "fa7"};
      5'd18:   n = {8'h0, "fs2"};
      5'd19:   n = {8'h0, "fs3"};
      5'd20:   n = {8'h0, "fs4"};
      5'd21:   n = {8'h0, "fs5"};
      5'd22:   n = {8'h0, "fs6"};
      5'd23:   n = {8'h0, "fs7"};
      5'd24:   n = {8'h0, "fs8"};
      5'd25:   n = {8'h0, "fs9"};
      5'd26:   n = "fs10";
      5'd27:   n = "fs11";
      5'd28:   n = {8'h0, "ft8"};
      5'd29:   n = {8'h0, "ft9"};
      5'd30:   n = "ft10";
      default: n = "ft11";
    endcase
    return n;
  endfunction
`endif

  // Stage p0: combinational lookup, one identical function per lane.
  logic [31:0] rd_p0, rs1_p0, rs2_p0;

`ifdef GETREG_FP_NAMES_EN
  assign rd_p0  = fp_sel[0] ? fp_name(idx_rd)  : int_name(idx_rd);
  assign rs1_p0 = fp_sel[1] ? fp_name(idx_rs1) : int_name(idx_rs1);
  assign rs2_p0 = fp_sel[2] ? fp_name(idx_rs2) : int_name(idx_rs2);
`else
  assign rd_p0  = int_name(idx_rd);
  assign rs1_p0 = int_name(idx_rs1);
  assign rs2_p0 = int_name(idx_rs2);
`endif

  generate
    if (REG_OUT != 0) begin : g_reg
      // Stage p1: names load only on a request and hold otherwise.
      logic        vld_p1;
      logic [31:0] rd_p1, rs1_p1, rs2_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1 <= 1'b0;
          rd_p1  <= 32'h0;
          rs1_p1 <= 32'h0;
          rs2_p1 <= 32'h0;
        end else begin
          vld_p1 <= in_valid;
          if (in_valid) begin
            rd_p1  <= rd_p0;
            rs1_p1 <= rs1_p0;
            rs2_p1 <= rs2_p0;
          end
        end
      end

      assign out_valid = vld_p1;
      assign name_rd   = rd_p1;
      assign name_rs1  = rs1_p1;
      assign name_rs2  = rs2_p1;
    end else begin : g_comb
      // Reset still masks the strobe so nothing is reported valid while held in reset.
      assign out_valid = in_valid & rst_n;
      assign name_rd   = rd_p0;
      assign name_rs1  = rs1_p0;
      assign name_rs2  = rs2_p0;
    end
  endgenerate

endmodule

// File: tb/tb_getreg.sv
// tb_getreg: directed scoreboard bench for getreg, registered and combinational instances side by side.
module tb_getreg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  idx_rd, idx_rs1, idx_rs2;
  logic [2:0]  fp_sel_t;

  logic        ov1, ov0;
  logic [31:0] rd1, rs11, rs21;
  logic [31:0] rd0, rs10, rs20;

  always #5 clk = ~clk;

  getreg #(.REG_OUT(1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .idx_rd(idx_rd), .idx_rs1(idx_rs1), .idx_rs2(idx_rs2),
`ifdef GETREG_FP_NAMES_EN
    .fp_sel(fp_sel_t),
`endif
    .out_valid(ov1), .name_rd(rd1), .name_rs1(rs11), .name_rs2(rs21)
  );

  getreg #(.REG_OUT(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .idx_rd(idx_rd), .idx_rs1(idx_rs1), .idx_rs2(idx_rs2),
`ifdef GETREG_FP_NAMES_EN
    .fp_sel(fp_sel_t),
`endif
    .out_valid(ov0), .name_rd(rd0), .name_rs1(rs10), .name_rs2(rs20)
  );

  typedef struct {
    logic [31:0] rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  exp_t sbq[$];
  exp_t held;
  int   ntests = 0;
  int   nfail  = 0;

  string int_tab[32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                         "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                         "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                         "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
  string fp_tab[32]  = '{"ft0", "ft1", "ft2", "ft3", "ft4", "ft5", "ft6", "ft7",
                         "fs0", "fs1", "fa0", "fa1", "fa2", "fa3", "fa4", "fa5",
                         "fa6", "fa7", "fs2", "fs3", "fs4", "fs5", "fs6", "fs7",
                         "fs8", "fs9", "fs10", "fs11", "ft8", "ft9", "ft10", "ft11"};

  function automatic logic [31:0] pack(input string s);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < s.len(); i++) r = {r[23:0], s[i]};
    return r;
  endfunction

  function automatic logic [31:0] model(input logic [4:0] idx, input logic fp);
`ifdef GETREG_FP_NAMES_EN
    if (fp) return pack(fp_tab[idx]);
`else
    if (fp) return pack(int_tab[idx]);
`endif
    return pack(int_tab[idx]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sbq_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_vld"}, {31'h0, ov1}, 32'h1);
      check({tag, "_rd"},  rd1,  e.rd);
      check({tag, "_rs1"}, rs11, e.rs1);
      check({tag, "_rs2"}, rs21, e.rs2);
      held = e;
    end
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [2:0] f, input string tag);
    exp_t e;
    idx_rd = a; idx_rs1 = b; idx_rs2 = c; fp_sel_t = f; in_valid = 1'b1;
    e.rd  = model(a, f[0]);
    e.rs1 = model(b, f[1]);
    e.rs2 = model(c, f[2]);
    sbq.push_back(e);
    @(posedge clk); #1;
    pop_check(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, {31'h0, ov1}, 32'h0);
    check({tag, "_rd"},  rd1,  32'h0);
    check({tag, "_rs1"}, rs11, 32'h0);
    check({tag, "_rs2"}, rs21, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; fp_sel_t = 3'b000;
    idx_rd = 5'd0; idx_rs1 = 5'd0; idx_rs2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_init");
    rst_n = 1'b1;

    // Reset asserted mid-cycle while a result is valid
    issue(5'd1, 5'd2, 5'd3, 3'b000, "pre_reset");
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    in_valid = 1'b1; idx_rd = 5'd7; idx_rs1 = 5'd8; idx_rs2 = 5'd9;
    @(posedge clk); #1;
    check_zero("drop_in_reset");
    in_valid = 1'b0; rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_zero("idle_after_reset");
    end

    // Sweep all indices on all lanes, spot-check against literal encodings
    for (int i = 0; i < 32; i++) begin
      issue(i[4:0], i[4:0], i[4:0], 3'b000, "sweep");
      case (i)
        0:  check("lit_idx0",  rd1, 32'h7A65726F);
        1:  check("lit_idx1",  rs11, 32'h00007261);
        8:  check("lit_idx8",  rs21, 32'h00007330);
        26: check("lit_idx26", rd1, 32'h00733130);
        31: check("lit_idx31", rs11, 32'h00007436);
        default: ;
      endcase
    end

    // Random triples, back to back
    for (int k = 0; k < 8; k++)
      issue(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)), 3'b000, "rand");

    issue(5'd10, 5'd2, 5'd0, 3'b000, "mixed");
    check("mixed_lit_rd",  rd1,  32'h00006130);
    check("mixed_lit_rs1", rs11, 32'h00007370);
    check("mixed_lit_rs2", rs21, 32'h7A65726F);

    // Hold with indices changing
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx_rd = 5'(k + 20); idx_rs1 = 5'(k + 4); idx_rs2 = 5'(31 - k);
      @(posedge clk); #1;
      check("hold_vld", {31'h0, ov1}, 32'h0);
      check("hold_rd",  rd1,  held.rd);
      check("hold_rs1", rs11, held.rs1);
      check("hold_rs2", rs21, held.rs2);
    end

`ifdef GETREG_FP_NAMES_EN
    issue(5'd27, 5'd27, 5'd27, 3'b001, "fp");
    check("fp_lit_rd",  rd1,  32'h66733131);
    check("fp_lit_rs1", rs11, 32'h00733131);
    issue(5'd0, 5'd30, 5'd8, 3'b110, "fp_mix");
`endif

    check("sbq_drained", 32'(sbq.size()), 32'd0);

    // Combinational instance, changes away from clock edges
    fp_sel_t = 3'b000;
    @(negedge clk);
    in_valid = 1'b1; idx_rd = 5'd5; idx_rs1 = 5'd9; idx_rs2 = 5'd17;
    #1;
    check("comb_rd5",  rd0, 32'h00007430);
    check("comb_rs1",  rs10, model(5'd9, 1'b0));
    check("comb_rs2",  rs20, model(5'd17, 1'b0));
    check("comb_vld1", {31'h0, ov0}, 32'h1);
    idx_rd = 5'd28;
    #1;
    check("comb_rd28", rd0, 32'h00007433);
    in_valid = 1'b0;
    #1;
    check("comb_vld0", {31'h0, ov0}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
